// File: rtl/fifo_mem_sched.sv
// Access scheduler and pointer controller for the fifo_mem dual-port array.
// Optional almost_full output is enabled by defining FIFO_SCHED_AFULL_EN.
module fifo_mem_sched #(
  parameter int unsigned Data_Width   = 8,
  parameter int unsigned Addr_Width   = 4,
  parameter int unsigned AFULL_THRESH = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr0_req,
  input  logic [Data_Width-1:0] wr0_data,
  output logic                  wr0_gnt,
  input  logic                  wr1_req,
  input  logic [Data_Width-1:0] wr1_data,
  output logic                  wr1_gnt,
  input  logic                  rd_req,
  output logic                  rd_gnt,
  output logic                  rd_valid,
  output logic [Data_Width-1:0] mem_w_data,
  output logic [Addr_Width-1:0] mem_w_addr,
  output logic [Addr_Width-1:0] mem_r_addr,
  output logic                  mem_wclken,
  output logic                  mem_rempty,
  output logic                  full,
  output logic                  empty,
  output logic [Addr_Width:0]   count
`ifdef FIFO_SCHED_AFULL_EN
  ,
  output logic                  almost_full
`endif
);

  localparam int unsigned DEPTH = 2 ** Addr_Width;
  localparam int unsigned CW    = Addr_Width + 1;

  localparam logic [1:0] PRIO_WR0 = 2'd0;
  localparam logic [1:0] PRIO_WR1 = 2'd1;
  localparam logic [1:0] PRIO_RD  = 2'd2;

  logic [1:0]            prio;
  logic [1:0]            prio_nxt;
  logic [Addr_Width-1:0] wptr;
  logic [Addr_Width-1:0] rptr;
  logic [CW-1:0]         count_nxt;
  logic                  elig_wr0;
  logic                  elig_wr1;
  logic                  elig_rd;
  logic                  wr_any;

  // Round-robin priority register
  always_ff @(posedge clk) begin
    if (rst) begin
      prio <= PRIO_WR0;
    end else begin
      prio <= prio_nxt;
    end
  end

  // Single grant per cycle: walk the ring from prio, first eligible wins
  always_comb begin
    wr0_gnt  = 1'b0;
    wr1_gnt  = 1'b0;
    rd_gnt   = 1'b0;
    prio_nxt = prio;
    elig_wr0 = wr0_req && !full;
    elig_wr1 = wr1_req && !full;
    elig_rd  = rd_req && !empty;

    if (!rst) begin
      case (prio)
        PRIO_WR1: begin
          if (elig_wr1)      wr1_gnt = 1'b1;
          else if (elig_rd)  rd_gnt  = 1'b1;
          else if (elig_wr0) wr0_gnt = 1'b1;
        end
        PRIO_RD: begin
          if (elig_rd)       rd_gnt  = 1'b1;
          else if (elig_wr0) wr0_gnt = 1'b1;
          else if (elig_wr1) wr1_gnt = 1'b1;
        end
        default: begin
          if (elig_wr0)      wr0_gnt = 1'b1;
          else if (elig_wr1) wr1_gnt = 1'b1;
          else if (elig_rd)  rd_gnt  = 1'b1;
        end
      endcase
    end

    if (wr0_gnt)      prio_nxt = PRIO_WR1;
    else if (wr1_gnt) prio_nxt = PRIO_RD;
    else if (rd_gnt)  prio_nxt = PRIO_WR0;
  end

  // Array-side strobes follow the grant of the current cycle
  always_comb begin
    wr_any     = wr0_gnt || wr1_gnt;
    mem_wclken = wr_any;
    mem_rempty = !rd_gnt;
    mem_w_addr = wptr;
    mem_r_addr = rptr;
    mem_w_data = '0;
    if (wr0_gnt)      mem_w_data = wr0_data;
    else if (wr1_gnt) mem_w_data = wr1_data;

    count_nxt = count;
    if (wr_any)      count_nxt = count + CW'(1);
    else if (rd_gnt) count_nxt = count - CW'(1);
  end

  // Pointers, occupancy and flags; flags are decoded from the next count so
  // they line up with the registered count
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      rd_valid <= 1'b0;
    end else begin
      if (wr_any) wptr <= wptr + Addr_Width'(1);
      if (rd_gnt) rptr <= rptr + Addr_Width'(1);
      count    <= count_nxt;
      full     <= (count_nxt == CW'(DEPTH));
      empty    <= (count_nxt == '0);
      rd_valid <= rd_gnt;
    end
  end

`ifdef FIFO_SCHED_AFULL_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      almost_full <= 1'b0;
    end else begin
      almost_full <= (32'(count_nxt) >= AFULL_THRESH);
    end
  end
`else
  logic unused_afull_thresh;
  assign unused_afull_thresh = ^AFULL_THRESH;
`endif

endmodule

// File: tb/tb_fifo_mem_sched.sv
// Scoreboard bench for fifo_mem_sched with a behavioural fifo_mem array model.
module tb_fifo_mem_sched;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic          clk;
  logic          rst;
  logic          wr0_req;
  logic [DW-1:0] wr0_data;
  logic          wr0_gnt;
  logic          wr1_req;
  logic [DW-1:0] wr1_data;
  logic          wr1_gnt;
  logic          rd_req;
  logic          rd_gnt;
  logic          rd_valid;
  logic [DW-1:0] mem_w_data;
  logic [AW-1:0] mem_w_addr;
  logic [AW-1:0] mem_r_addr;
  logic          mem_wclken;
  logic          mem_rempty;
  logic          full;
  logic          empty;
  logic [AW:0]   count;
`ifdef FIFO_SCHED_AFULL_EN
  logic          almost_full;
`endif

  fifo_mem_sched #(.Data_Width(DW), .Addr_Width(AW), .AFULL_THRESH(12)) dut (
    .clk        (clk),
    .rst        (rst),
    .wr0_req    (wr0_req),
    .wr0_data   (wr0_data),
    .wr0_gnt    (wr0_gnt),
    .wr1_req    (wr1_req),
    .wr1_data   (wr1_data),
    .wr1_gnt    (wr1_gnt),
    .rd_req     (rd_req),
    .rd_gnt     (rd_gnt),
    .rd_valid   (rd_valid),
    .mem_w_data (mem_w_data),
    .mem_w_addr (mem_w_addr),
    .mem_r_addr (mem_r_addr),
    .mem_wclken (mem_wclken),
    .mem_rempty (mem_rempty),
    .full       (full),
    .empty      (empty),
    .count      (count)
`ifdef FIFO_SCHED_AFULL_EN
    ,
    .almost_full(almost_full)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Array model: write at the edge, read suppressed when a write is enabled
  logic [DW-1:0] mem_arr [DEPTH];
  logic [DW-1:0] r_data;
  always @(posedge clk) begin
    if (mem_wclken) mem_arr[mem_w_addr] <= mem_w_data;
    if (!mem_rempty && !mem_wclken) r_data <= mem_arr[mem_r_addr];
  end

  int            errors = 0;
  int            checks = 0;
  logic [DW-1:0] exp_q [$];
  int            exp_count = 0;
  logic [AW-1:0] exp_wptr = '0;
  logic [AW-1:0] exp_rptr = '0;
  logic          prev_gnt = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One cycle: drive at negedge, check combinational grants and registered state
  task automatic step(input bit r, input bit w0, input logic [DW-1:0] d0,
                      input bit w1, input logic [DW-1:0] d1, input bit rq,
                      input bit eg0, input bit eg1, input bit egr, input string tag);
    logic [DW-1:0] exp_wd;
    @(negedge clk);
    rst      = r;
    wr0_req  = w0;
    wr0_data = d0;
    wr1_req  = w1;
    wr1_data = d1;
    rd_req   = rq;
    #1;
    exp_wd = eg0 ? d0 : (eg1 ? d1 : '0);
    chk({tag, ".wr0_gnt"},    wr0_gnt, eg0);
    chk({tag, ".wr1_gnt"},    wr1_gnt, eg1);
    chk({tag, ".rd_gnt"},     rd_gnt, egr);
    chk({tag, ".wclken"},     mem_wclken, eg0 | eg1);
    chk({tag, ".rempty"},     mem_rempty, !egr);
    chk({tag, ".excl"},       mem_wclken & !mem_rempty, 0);
    chk({tag, ".count"},      count, 32'(exp_count));
    chk({tag, ".full"},       full, exp_count == DEPTH);
    chk({tag, ".empty"},      empty, exp_count == 0);
    chk({tag, ".w_addr"},     mem_w_addr, exp_wptr);
    chk({tag, ".r_addr"},     mem_r_addr, exp_rptr);
    chk({tag, ".w_data"},     mem_w_data, exp_wd);
`ifdef FIFO_SCHED_AFULL_EN
    chk({tag, ".almost_full"}, almost_full, exp_count >= 12);
`endif
    if (r) begin
      exp_count = 0;
      exp_wptr  = '0;
      exp_rptr  = '0;
      exp_q.delete();
    end else begin
      if (eg0 || eg1) begin
        exp_q.push_back(exp_wd);
        exp_wptr  = exp_wptr + 4'd1;
        exp_count = exp_count + 1;
      end
      if (egr) begin
        exp_rptr  = exp_rptr + 4'd1;
        exp_count = exp_count - 1;
      end
    end
  endtask

  // Monitor: rd_valid must follow rd_gnt by one cycle; data popped in order
  initial begin
    logic [DW-1:0] want;
    forever begin
      @(negedge clk);
      chk("mon.rd_valid", rd_valid, prev_gnt);
      if (rd_valid === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL mon.r_data: got %0h with no expected entry", r_data);
        end else begin
          want = exp_q.pop_front();
          if (r_data !== want) begin
            errors++;
            $display("FAIL mon.r_data: got %0h expected %0h", r_data, want);
          end
        end
      end
      #2;
      prev_gnt = rd_gnt;
    end
  end

  initial begin
    logic [DW-1:0] d0;
    logic [DW-1:0] d1;
    rst = 1'b1; wr0_req = 1'b0; wr1_req = 1'b0; rd_req = 1'b0;
    wr0_data = '0; wr1_data = '0;

    // Reset cycle blocks grants even with a request present; then idle
    step(1, 1, 8'h11, 0, 8'h00, 0, 0, 0, 0, "rst");
    step(0, 0, 8'h00, 0, 8'h00, 0, 0, 0, 0, "idle");

    // Fill to full with wr0, then the 17th request is refused
    for (int i = 0; i < 16; i++) step(0, 1, 8'(i), 0, 8'h00, 0, 1, 0, 0, "fill");
    step(0, 1, 8'hFF, 0, 8'h00, 0, 0, 0, 0, "full_block");

    // prio names wr1 here, but full blocks writers and the read wins
    step(0, 1, 8'hFF, 1, 8'hEE, 1, 0, 0, 1, "full_rd_wins");
    for (int i = 1; i < 16; i++) step(0, 0, 8'h00, 0, 8'h00, 1, 0, 0, 1, "drain");
    step(0, 0, 8'h00, 0, 8'h00, 1, 0, 0, 0, "empty_block");

    // Bring count to 8 with prio back at wr0
    for (int i = 0; i < 9; i++) step(0, 1, 8'(48 + i), 0, 8'h00, 0, 1, 0, 0, "half");
    step(0, 0, 8'h00, 0, 8'h00, 1, 0, 0, 1, "half_rd");

    // All three requesters held: wr0, wr1, rd rotation
    d0 = 8'h40;
    d1 = 8'h80;
    for (int k = 0; k < 9; k++) begin
      case (k % 3)
        0: begin step(0, 1, d0, 1, d1, 1, 1, 0, 0, "rot"); d0 = d0 + 8'd1; end
        1: begin step(0, 1, d0, 1, d1, 1, 0, 1, 0, "rot"); d1 = d1 + 8'd1; end
        default: step(0, 1, d0, 1, d1, 1, 0, 0, 1, "rot");
      endcase
    end
    for (int i = 0; i < 11; i++) step(0, 0, 8'h00, 0, 8'h00, 1, 0, 0, 1, "drain2");
    step(0, 0, 8'h00, 0, 8'h00, 1, 0, 0, 0, "empty2");

    // Wrap-around with shallow occupancy
    for (int k = 0; k < 20; k++) begin
      step(0, 0, 8'h00, 1, 8'(160 + k), 0, 0, 1, 0, "wrap_wr");
      step(0, 0, 8'h00, 0, 8'h00, 1, 0, 0, 1, "wrap_rd");
    end
    step(0, 0, 8'h00, 0, 8'h00, 0, 0, 0, 0, "wrap_idle");

    // Reset one cycle after a read grant
    step(0, 1, 8'h5A, 0, 8'h00, 0, 1, 0, 0, "pre_rst_wr");
    step(0, 0, 8'h00, 0, 8'h00, 1, 0, 0, 1, "pre_rst_rd");
    step(1, 1, 8'h77, 0, 8'h00, 1, 0, 0, 0, "rst_mid");
    step(0, 0, 8'h00, 0, 8'h00, 0, 0, 0, 0, "post_rst");
    chk("post_rst.rd_valid", rd_valid, 0);

    // prio returns to wr0: leave it at wr1, reset, then both writers contend
    step(0, 1, 8'h61, 0, 8'h00, 0, 1, 0, 0, "prio_set");
    step(1, 0, 8'h00, 0, 8'h00, 0, 0, 0, 0, "prio_rst");
    step(0, 1, 8'h62, 1, 8'h63, 0, 1, 0, 0, "prio_wr0");
    step(0, 0, 8'h00, 0, 8'h00, 1, 0, 0, 1, "prio_rd");
    step(0, 0, 8'h00, 0, 8'h00, 0, 0, 0, 0, "final_idle");
    step(0, 0, 8'h00, 0, 8'h00, 0, 0, 0, 0, "final_idle");

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fifo_mem_sched.md
# fifo_mem_sched

Single-clock access scheduler and pointer controller for the `fifo_mem` dual-port storage array. It arbitrates two write requesters and one read requester onto the array, granting one access per cycle. It owns the write/read pointers, the occupancy count and the full/empty flags. It drives `w_addr`, `wclken`, `r_addr` and `rempty` of a `fifo_mem` instance whose `wclk` and `rclk` are both tied to `clk`.

## Interface
- `Data_Width`, 8, word width; matches `fifo_mem`.
- `Addr_Width`, 4, address width; depth = 2**Addr_Width.
- `AFULL_THRESH`, 12, almost-full level; used only with `FIFO_SCHED_AFULL_EN`.

Ports:
- `clk`  in  1  single clock; also drives `wclk`/`rclk` of the array.
- `rst`  in  1  synchronous, active-high reset.
- `wr0_req`, `wr1_req`  in  1  write requests.
- `wr0_data`, `wr1_data`  in  Data_Width  write data.
- `wr0_gnt`, `wr1_gnt`  out  1  write granted; transfer when req && gnt.
- `rd_req`  in  1  read request.
- `rd_gnt`  out  1  read granted this cycle.
- `rd_valid`  out  1  array `r_data` valid; one cycle after `rd_gnt`.
- `mem_w_data`  out  Data_Width  to array `w_data`.
- `mem_w_addr`, `mem_r_addr`  out  Addr_Width  to array `w_addr`/`r_addr`.
- `mem_wclken`  out  1  to array `wclken`.
- `mem_rempty`  out  1  to array `rempty`.
- `full`, `empty`  out  1  occupancy flags.
- `count`  out  Addr_Width+1  occupancy, 0..2**Addr_Width.
- `almost_full`  out  1  only with `FIFO_SCHED_AFULL_EN`.

## Operation
- Eligibility: `wrN` eligible iff `wrN_req && !full`; `rd` eligible iff `rd_req && !empty`.
- Round-robin over the ring wr0 → wr1 → rd → wr0. Register `prio` (2 bits) names the highest-priority requester. The first eligible requester found from `prio` is granted. After a grant, `prio` becomes the requester after the one granted. With no grant, `prio` holds.
- At most one grant per cycle. This is required because the array suppresses reads in any cycle with `wclken` high.
- Write grant:
  - `mem_wclken`=1.
  - `mem_w_data` = granted writer's data; 0 when idle.
  - `mem_w_addr` = `wptr`.
  - At the edge: `wptr` += 1 mod depth, and `count` += 1.
- Read grant:
  - `mem_rempty`=0 and `mem_r_addr` = `rptr`.
  - At the edge: `rptr` += 1 mod depth, and `count` -= 1.
  - The following cycle: `rd_valid`=1.
- `mem_rempty`=1 in every cycle without a read grant. `mem_r_addr` = `rptr` always.
- `full` = (`count` == 2**Addr_Width). `empty` = (`count` == 0). Both are decoded from registered `count`.
- Pointer wrap is natural mod-2**Addr_Width. `count` never over- or underflows, because ineligible requesters are never granted.
- `almost_full` = (`count` >= `AFULL_THRESH`).
- Reset values:
  - `wptr`, `rptr`, `count` = 0.
  - `prio` = wr0.
  - `rd_valid` = 0, `full` = 0, `empty` = 1.
  - All grants = 0 and `mem_wclken` = 0 during the reset cycle; `mem_rempty` = 1.
- Reset mid-operation: any in-flight `rd_valid` is cleared. Array contents are untouched but logically discarded.

## Timing
- Grants are combinational from the requests and registered state, in the same cycle. A requester holds `req` until it sees `gnt`; `wrN_data` must be stable while `req` is high.
- Write latency: data is in the array at the granting edge. A read of that entry can be granted the next cycle at the earliest.
- Read latency: 1 cycle. Array `r_data` updates at the grant edge and is sampled while `rd_valid`=1.
- Back-to-back reads give `rd_valid` high on consecutive cycles.
- When full, writes are blocked and a pending read wins regardless of `prio`. When empty, reads are blocked.
- Full and empty are mutually exclusive, since depth ≥ 2.

## Configuration
- `FIFO_SCHED_AFULL_EN` defined: the `almost_full` port and its comparator against `AFULL_THRESH` are present.
- `FIFO_SCHED_AFULL_EN` undefined: the `almost_full` port is absent, `AFULL_THRESH` is unused, and all other behaviour is identical.

## Test plan
- Reset, then idle: `empty`=1, `full`=0, `count`=0, all grants 0, `mem_rempty`=1, `mem_wclken`=0.
- `wr0_req` held with data 0x00..0x0F, no other requests: 16 grants on consecutive cycles, then `full`=1, `count`=16, and `wr0_gnt`=0 on the 17th cycle. `almost_full` (if enabled) rises when `count` reaches 12.
- From full, `rd_req` held: 16 reads return 0x00..0x0F in order, with `rd_valid` one cycle after each `rd_gnt`. Then `empty`=1 and `rd_gnt`=0.
- `wr0_req`, `wr1_req` and `rd_req` all held with FIFO half full (`count`=8): grants rotate wr0, wr1, rd, wr0, …. `count` rises by 1 per 3 cycles, and `mem_wclken` and `!mem_rempty` are never both high.
- Wrap-around: 20 write/read pairs with `count` ≤ 2. Pointers wrap past 15→0 and read data matches write order.
- Assert `rst` one cycle after a read grant: `rd_valid`=0 next cycle, `count`=0, `empty`=1, `prio`=wr0.
